// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for the ALU sharing controller and its neighbours.
package alu_pkg;

    localparam logic [2:0] OP_PASS = 3'd0;
    localparam logic [2:0] OP_NOT  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;
    localparam logic [2:0] OP_SLT  = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    // The ALU keeps stale output for op 7, so an illegal op is issued as PASS.
    function automatic logic [2:0] alu_drive_op(input logic [2:0] op);
        return (op == OP_ILL) ? OP_PASS : op;
    endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle between the two requesters and the ALU sharing controller.
interface alu_share_ctrl_if #(parameter int W = 32);
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [2:0]   req_op0, req_op1;
    logic [W-1:0] req_a0, req_a1;
    logic [W-1:0] req_b0, req_b1;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_cout;
    logic         rsp_err;

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_cout, rsp_err
    );
    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_cout, rsp_err
    );
endinterface

// File: rtl/alu_rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the requester favoured on a tie.
module alu_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    input  logic       upd,
    output logic [1:0] gnt
);
    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // After a grant the tie-break favours whoever lost.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= 1'b0;
        else if (upd && (gnt != 2'b00))
            ptr <= gnt[0];
    end
endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one registered ALU between two requesters: round-robin grant, operand hold, result return.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_share_ctrl_if.slave bus,
    output logic [2:0]    alu_op,
    output logic [W-1:0]  alu_r2,
    output logic [W-1:0]  alu_r3,
    input  logic [W-1:0]  alu_r0,
    input  logic          alu_cout
);
    state_t       state, nxt;
    logic         owner;
    logic         ill;
    logic [1:0]   gnt;
    logic         hs;
    logic [2:0]   sel_op;
    logic [W-1:0] sel_a, sel_b;

    alu_rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (bus.req_valid),
        .en  ((state == IDLE) && !rst),
        .upd (hs),
        .gnt (gnt)
    );

    assign bus.req_ready = gnt;
    assign hs            = |(bus.req_valid & gnt);
    assign sel_op        = gnt[1] ? bus.req_op1 : bus.req_op0;
    assign sel_a         = gnt[1] ? bus.req_a1  : bus.req_a0;
    assign sel_b         = gnt[1] ? bus.req_b1  : bus.req_b0;
    assign bus.rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (hs) nxt = EXEC;
            EXEC:    nxt = CAPT;
            CAPT:    nxt = RESP;
            RESP:    if (bus.rsp_ready[owner]) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // ALU inputs are loaded at the handshake and then simply held until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner        <= 1'b0;
            ill          <= 1'b0;
            alu_op       <= OP_PASS;
            alu_r2       <= '0;
            alu_r3       <= '0;
            bus.rsp_data <= '0;
            bus.rsp_cout <= 1'b0;
            bus.rsp_err  <= 1'b0;
        end else begin
            if (hs) begin
                owner  <= gnt[1];
                ill    <= (sel_op == OP_ILL);
                alu_op <= alu_drive_op(sel_op);
                alu_r2 <= sel_a;
                alu_r3 <= sel_b;
            end
            if (state == CAPT) begin
                bus.rsp_data <= ill ? '0 : alu_r0;
                bus.rsp_cout <= ill ? 1'b0 : alu_cout;
                bus.rsp_err  <= ill;
            end
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: registered ALU model, per-cycle transaction-level reference, directed and random traffic.
module tb_alu_share_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_share_ctrl_if #(.W(32)) bus();
    logic [2:0]  alu_op;
    logic [31:0] alu_r2, alu_r3;
    logic [31:0] alu_r0 = '0;
    logic        alu_cout = 1'b0;

    alu_share_ctrl #(.W(32)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_op(alu_op), .alu_r2(alu_r2), .alu_r3(alu_r3),
        .alu_r0(alu_r0), .alu_cout(alu_cout)
    );

    // Registered ALU: one cycle latency, holds its output for op 7.
    always @(posedge clk) begin
        case (alu_op)
            3'd0: begin alu_r0 <= alu_r2;          alu_cout <= 1'b0; end
            3'd1: begin alu_r0 <= ~alu_r2;         alu_cout <= 1'b0; end
            3'd2: {alu_cout, alu_r0} <= {1'b0, alu_r2} + {1'b0, alu_r3};
            3'd3: {alu_cout, alu_r0} <= {1'b0, alu_r2} - {1'b0, alu_r3};
            3'd4: begin alu_r0 <= alu_r2 | alu_r3; alu_cout <= 1'b0; end
            3'd5: begin alu_r0 <= alu_r2 & alu_r3; alu_cout <= 1'b0; end
            3'd6: begin alu_r0 <= {31'b0, $signed(alu_r2) < $signed(alu_r3)}; alu_cout <= 1'b0; end
            default: ;
        endcase
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic void ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] d, output logic c, output logic e);
        longint s;
        d = '0; c = 1'b0; e = 1'b0;
        case (op)
            3'd0: d = a;
            3'd1: d = ~a;
            3'd2: begin s = longint'(a) + longint'(b); d = s[31:0]; c = (s > 64'hFFFF_FFFF); end
            3'd3: begin d = a - b; c = (a < b); end
            3'd4: d = a | b;
            3'd5: d = a & b;
            3'd6: d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: e = 1'b1;
        endcase
    endfunction

    function automatic logic [1:0] rr_pick(input logic [1:0] v, input logic p);
        if (v == 2'b11) return p ? 2'b10 : 2'b01;
        return v;
    endfunction

    // Reference: a transaction is in flight for a number of cycles since acceptance.
    logic        m_busy = 1'b0, m_owner = 1'b0, m_ptr = 1'b0;
    int          m_age = 0;
    logic [2:0]  m_aop = '0;
    logic [31:0] m_a = '0, m_b = '0, m_d = '0, p_d = '0;
    logic        m_c = 1'b0, m_e = 1'b0, p_c = 1'b0, p_e = 1'b0;
    int          hs_cyc = 0;
    int          g_owner[$];
    int          g_cyc[$];
    logic        l_seen = 1'b0;
    int          l_cyc = 0;
    logic [1:0]  l_v = '0;
    logic [31:0] l_d = '0, l1_d = '0;
    logic        l_c = 1'b0, l_e = 1'b0;
    int          n_rsp = 0;

    task automatic tick();
        logic [1:0]  er, ev;
        logic [2:0]  op;
        #1;
        er = (rst || m_busy) ? 2'b00 : rr_pick(bus.req_valid, m_ptr);
        ev = (m_busy && m_age >= 3) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        chk("req_ready", 32'(bus.req_ready), 32'(er));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(ev));
        chk("rsp_data",  bus.rsp_data, m_d);
        chk("rsp_cout",  32'(bus.rsp_cout), 32'(m_c));
        chk("rsp_err",   32'(bus.rsp_err), 32'(m_e));
        chk("alu_op",    32'(alu_op), 32'(m_aop));
        chk("alu_r2",    alu_r2, m_a);
        chk("alu_r3",    alu_r3, m_b);
        if (bus.rsp_valid != 2'b00) begin
            if (!l_seen) begin
                l_seen = 1'b1; l_cyc = cyc; l_v = bus.rsp_valid;
                l_d = bus.rsp_data; l_c = bus.rsp_cout; l_e = bus.rsp_err;
            end
            if (bus.rsp_valid == 2'b10) l1_d = bus.rsp_data;
        end
        if (rst) begin
            m_busy = 1'b0; m_ptr = 1'b0; m_aop = '0; m_a = '0; m_b = '0;
            m_d = '0; m_c = 1'b0; m_e = 1'b0;
        end else if (!m_busy && er != 2'b00) begin
            m_busy  = 1'b1; m_age = 1; m_owner = er[1]; m_ptr = ~er[1];
            op      = er[1] ? bus.req_op1 : bus.req_op0;
            m_a     = er[1] ? bus.req_a1 : bus.req_a0;
            m_b     = er[1] ? bus.req_b1 : bus.req_b0;
            m_aop   = (op == 3'd7) ? 3'd0 : op;
            ref_calc(op, m_a, m_b, p_d, p_c, p_e);
            hs_cyc  = cyc;
            g_owner.push_back(int'(er[1]));
            g_cyc.push_back(cyc);
        end else if (m_busy) begin
            if (m_age == 2) begin
                m_d = p_d; m_c = p_c; m_e = p_e; m_age = 3;
            end else if (m_age >= 3) begin
                if (bus.rsp_ready[m_owner]) begin m_busy = 1'b0; n_rsp++; end
            end else begin
                m_age++;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_txn(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        l_seen = 1'b0;
        bus.rsp_ready = 2'b11;
        bus.req_valid = id ? 2'b10 : 2'b01;
        if (id) begin bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b; end
        else    begin bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b; end
        tick();
        bus.req_valid = 2'b00;
        repeat (3) tick();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom_range(0, 15);
        endcase
    endfunction

    typedef struct {
        logic        id;
        logic [2:0]  op;
        logic [31:0] a, b, d;
        logic        c, e;
    } vec_t;
    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b0, 3'd2, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
        tbl[1]  = '{1'b0, 3'd2, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};
        tbl[2]  = '{1'b1, 3'd3, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b1, 1'b0};
        tbl[3]  = '{1'b0, 3'd6, 32'h8000_0000,  32'd1,          32'd1,          1'b0, 1'b0};
        tbl[4]  = '{1'b1, 3'd4, 32'hF0,         32'h0F,         32'hFF,         1'b0, 1'b0};
        tbl[5]  = '{1'b0, 3'd5, 32'hF0F0,       32'hFF00,       32'hF000,       1'b0, 1'b0};
        tbl[6]  = '{1'b1, 3'd1, 32'h0F0F_0F0F,  32'h1234,       32'hF0F0_F0F0,  1'b0, 1'b0};
        tbl[7]  = '{1'b0, 3'd0, 32'h1234_5678,  32'hDEAD,       32'h1234_5678,  1'b0, 1'b0};
        tbl[8]  = '{1'b1, 3'd7, 32'h55,         32'h66,         32'd0,          1'b0, 1'b1};
        tbl[9]  = '{1'b0, 3'd3, 32'd5,          32'd3,          32'd2,          1'b0, 1'b0};
        tbl[10] = '{1'b1, 3'd6, 32'd1,          32'h8000_0000,  32'd0,          1'b0, 1'b0};

        bus.req_valid = '0; bus.rsp_ready = '0;
        bus.req_op0 = '0; bus.req_op1 = '0;
        bus.req_a0 = '0; bus.req_a1 = '0; bus.req_b0 = '0; bus.req_b1 = '0;
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_txn(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b);
            chk("tbl_data",  l_d, tbl[i].d);
            chk("tbl_cout",  32'(l_c), 32'(tbl[i].c));
            chk("tbl_err",   32'(l_e), 32'(tbl[i].e));
            chk("tbl_owner", 32'(l_v), tbl[i].id ? 32'd2 : 32'd1);
            chk("tbl_lat",   32'(l_cyc - hs_cyc), 32'd3);
        end

        // Backpressure: response held for several cycles while both requesters wait.
        bus.rsp_ready = 2'b00;
        bus.req_valid = 2'b01; bus.req_op0 = 3'd3; bus.req_a0 = 32'd10; bus.req_b0 = 32'd4;
        tick();
        bus.req_valid = 2'b11;
        tick(); tick();
        for (int k = 0; k < 5; k++) begin
            bus.rsp_ready = (k == 2) ? 2'b10 : 2'b00;
            tick();
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_data",  bus.rsp_data, 32'd6);
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 2'b00; bus.rsp_ready = 2'b01;
        tick();
        chk("bp_release", 32'(bus.rsp_valid), 32'd0);

        // Reset while the ALU is executing abandons the transaction.
        bus.req_valid = 2'b01; bus.req_op0 = 3'd2; bus.req_a0 = 32'd5; bus.req_b0 = 32'd7;
        bus.rsp_ready = 2'b11;
        tick();
        bus.req_valid = 2'b00; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_valid",  32'(bus.rsp_valid), 32'd0);
        chk("rst_data",   bus.rsp_data, 32'd0);
        chk("rst_aluop",  32'(alu_op), 32'd0);
        chk("rst_r2",     alu_r2, 32'd0);
        repeat (4) tick();

        // Contention: both requesters valid, grants alternate from requester 0.
        g_owner.delete(); g_cyc.delete();
        bus.req_valid = 2'b11;
        bus.req_op0 = 3'd2; bus.req_a0 = 32'd1;    bus.req_b0 = 32'd2;
        bus.req_op1 = 3'd4; bus.req_a1 = 32'hF0;   bus.req_b1 = 32'h0F;
        l1_d = '0;
        repeat (16) tick();
        bus.req_valid = 2'b00;
        repeat (4) tick();
        chk("cont_n", 32'(g_owner.size()), 32'd4);
        for (int i = 0; i < g_owner.size() && i < 4; i++) begin
            chk("cont_owner", 32'(g_owner[i]), 32'(i % 2));
            if (i > 0) chk("cont_gap", 32'(g_cyc[i] - g_cyc[i-1]), 32'd4);
        end
        chk("cont_or", l1_d, 32'hFF);

        // Random traffic against the reference.
        n_rsp = 0;
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.req_valid = 2'($urandom);
            bus.rsp_ready = 2'($urandom);
            bus.req_op0 = 3'($urandom_range(0, 7)); bus.req_a0 = pick(); bus.req_b0 = pick();
            bus.req_op1 = 3'($urandom_range(0, 7)); bus.req_a1 = pick(); bus.req_b1 = pick();
            tick();
        end
        rst = 1'b0; bus.req_valid = 2'b00; bus.rsp_ready = 2'b11;
        repeat (5) tick();
        chk("rand_rsp_seen", 32'(n_rsp > 20), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
